legv8_encoder: RTL and testbench
================================

// Module: legv8_encoder
// PURPOSE
//  Inverse of the LEGv8 instruction decoder. It takes an instruction ID plus operand
//  fields and assembles the 32-bit LEGv8 machine word (R, I and B formats).
//  One input register stage feeds an output FIFO, with a valid/ready handshake on both sides.
//  It sits between the test-program generator and instruction memory / decoder loopback.
// PARAMETERS
//  FIFO_DEPTH  4   output FIFO entries; power of 2, >=2
//  COUNT_W     16  width of the encoded-word and error counters
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        synchronous, active-low reset
//  in_valid   in   1        request valid
//  in_ready   out  1        request accepted when in_valid && in_ready
//  in_id      in   6        instruction ID, legv8_pkg::instr_id_t (1..21)
//  in_rd      in   5        Rd / Rt
//  in_rn      in   5        Rn
//  in_rm      in   5        Rm
//  in_shamt   in   6        shift amount (LSL/LSR only)
//  in_imm     in   26       I: unsigned imm12 in [11:0]; B: signed BR_address
//  out_valid  out  1        out_word valid
//  out_ready  in   1        consumer takes the word when out_valid && out_ready
//  out_word   out  32       encoded instruction
//  out_err    out  1        word is invalid (illegal ID or imm out of range)
//  enc_count  out  COUNT_W  words emitted without error, saturating
//  err_count  out  COUNT_W  words emitted with error, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): S1 and FIFO emptied, all counters 0.
//   out_valid=0, out_word=0, out_err=0, in_ready=0 while rst_n=0.
//  Reset mid-stream drops every in-flight word. None appear after release.
//  in_ready = rst_n && (!s1_valid || s1_adv).
//   s1_adv = s1_valid && (!fifo_full || (out_valid && out_ready)).
//   This is a combinational path from out_ready to in_ready.
//  Accept at edge N: S1 valid after N. Word written to FIFO at edge N+1. out_valid=1 from N+1.
//  With out_ready held high, throughput is 1 word per clock. Latency is 2 edges.
//  Encoding, from S1 registers, with opcodes in legv8_pkg:
//   R:  {op11, Rm, shamt, Rn, Rd}. AND ADD ORR ADDS EOR SUB ANDS SUBS.
//       shamt field is forced 0.
//   LSL/LSR: Rm field forced 0. shamt = in_shamt.
//   BR: {op11, 5'b0, 6'b0, Rn, 5'b0}.
//   I:  {op10, imm[11:0], Rn, Rd}. ORRI EORI ADDI ANDI ADDIS SUBI SUBIS ANDIS.
//   B:  {op6, imm[25:0]}. B=000101, BL=100101.
//   EOR=11001010000, ANDS=11101010000. These are distinct and both must encode.
//  Error: in_id==0, in_id>21, or an I-format request with imm[25:12]!=0.
//   Result: out_word=0, out_err=1. The word is still emitted, so ordering is preserved.
//  Counters increment on the pop handshake, not on the push. They saturate at all-ones.
//  FIFO:
//   - push while full is allowed only with a same-cycle pop. Count is unchanged.
//   - push and pop while empty is not possible: read data is registered.
//   - pointers wrap modulo FIFO_DEPTH.
//  Changes to out_word/out_err while out_valid && !out_ready are forbidden.
// STRUCTURE
//  legv8_pkg:
//   - instr_id_t enum (B=1,BL=2,ORRI=3,EORI=4,ADDI=5,ANDI=6,ADDIS=7,SUBI=8,SUBIS=9,
//     ANDIS=10,AND=11,ADD=12,ORR=13,ADDS=14,EOR=15,SUB=16,LSR=17,LSL=18,BR=19,ANDS=20,SUBS=21).
//   - fmt_t {FMT_R, FMT_I, FMT_B, FMT_BAD}.
//   - OP11_*, OP10_*, OP6_* constants.
//   - function id2fmt().
//  Sub-module legv8_enc_fifo: WIDTH=33 ({err,word}), DEPTH=FIFO_DEPTH, registered output.
//  Encode logic is combinational between S1 and the FIFO push data.
// TESTING
//  1 ADD X3,X1,X2 (id12,rd3,rn1,rm2) -> 0x8B020023, err=0, enc_count=1.
//  2 ADDI X5,X6,#100 -> 0x910190C5; LSL X1,X2,#4 -> 0xD3601041; BR X30 -> 0xD60003C0.
//  3 B imm=26'h3FFFFFF -> 0x17FFFFFF; BL imm=1 -> 0x94000001; back-to-back, 1/clk.
//  4 id=0, then ADDI imm=4096 -> two words 0x00000000 with err=1, err_count=2, enc_count=0.
//  5 out_ready=0, offer 6 requests (depth 4): exactly 5 accepted, then in_ready=0.
//    Release out_ready: all 5 emerge in order, then the 6th is accepted.
//  6 FIFO holds 3 words, rst_n=0 for 1 edge -> out_valid=0, counters 0.
//    No stale word emerges after release.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoder definitions: instruction IDs, format classes, opcodes
// and the ID-to-format classifier.
package legv8_pkg;

  typedef enum logic [5:0] {
    ID_B     = 6'd1,
    ID_BL    = 6'd2,
    ID_ORRI  = 6'd3,
    ID_EORI  = 6'd4,
    ID_ADDI  = 6'd5,
    ID_ANDI  = 6'd6,
    ID_ADDIS = 6'd7,
    ID_SUBI  = 6'd8,
    ID_SUBIS = 6'd9,
    ID_ANDIS = 6'd10,
    ID_AND   = 6'd11,
    ID_ADD   = 6'd12,
    ID_ORR   = 6'd13,
    ID_ADDS  = 6'd14,
    ID_EOR   = 6'd15,
    ID_SUB   = 6'd16,
    ID_LSR   = 6'd17,
    ID_LSL   = 6'd18,
    ID_BR    = 6'd19,
    ID_ANDS  = 6'd20,
    ID_SUBS  = 6'd21
  } instr_id_t;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_B, FMT_BAD} fmt_t;

  localparam logic [10:0] OP11_AND  = 11'b10001010000;
  localparam logic [10:0] OP11_ADD  = 11'b10001011000;
  localparam logic [10:0] OP11_ORR  = 11'b10101010000;
  localparam logic [10:0] OP11_ADDS = 11'b10101011000;
  localparam logic [10:0] OP11_EOR  = 11'b11001010000;
  localparam logic [10:0] OP11_SUB  = 11'b11001011000;
  localparam logic [10:0] OP11_LSR  = 11'b11010011010;
  localparam logic [10:0] OP11_LSL  = 11'b11010011011;
  localparam logic [10:0] OP11_BR   = 11'b11010110000;
  localparam logic [10:0] OP11_ANDS = 11'b11101010000;
  localparam logic [10:0] OP11_SUBS = 11'b11101011000;

  localparam logic [9:0] OP10_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP10_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP10_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP10_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP10_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP10_EORI  = 10'b1101001000;
  localparam logic [9:0] OP10_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP10_ANDIS = 10'b1111001000;

  localparam logic [5:0] OP6_B  = 6'b000101;
  localparam logic [5:0] OP6_BL = 6'b100101;

  function automatic fmt_t id2fmt(input logic [5:0] id);
    if (id == 6'd1 || id == 6'd2)          return FMT_B;
    else if (id >= 6'd3 && id <= 6'd10)    return FMT_I;
    else if (id >= 6'd11 && id <= 6'd21)   return FMT_R;
    else                                   return FMT_BAD;
  endfunction

endpackage

// File: rtl/legv8_encoder_if.sv
// Request/response bundle of the LEGv8 encoder: request handshake, encoded
// word handshake and the emitted-word counters.
interface legv8_encoder_if #(
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         in_id;
  logic [4:0]         in_rd;
  logic [4:0]         in_rn;
  logic [4:0]         in_rm;
  logic [5:0]         in_shamt;
  logic [25:0]        in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_word;
  logic               out_err;
  logic [COUNT_W-1:0] enc_count;
  logic [COUNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_id, in_rd, in_rn, in_rm, in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_err, enc_count, err_count
  );

  modport master (
    output in_valid, in_id, in_rd, in_rn, in_rm, in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_err, enc_count, err_count
  );
endinterface

// File: rtl/legv8_enc_fifo.sv
// Small synchronous FIFO; the head entry is read straight from the storage
// registers, so a word pushed this cycle becomes visible only on the next one.
module legv8_enc_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = rst_n && (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/legv8_encoder.sv
// LEGv8 instruction encoder: one request register stage, combinational field
// assembly, then an output FIFO with saturating emitted/error counters.
module legv8_encoder
  import legv8_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  legv8_encoder_if.slave bus
);
  logic               r_vld_p1;
  logic [5:0]         r_id_p1;
  logic [4:0]         r_rd_p1;
  logic [4:0]         r_rn_p1;
  logic [4:0]         r_rm_p1;
  logic [5:0]         r_shamt_p1;
  logic [25:0]        r_imm_p1;
  logic [COUNT_W-1:0] r_enc_count;
  logic [COUNT_W-1:0] r_err_count;

  logic        w_accept;
  logic        w_s1_adv;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_valid;
  logic [32:0] w_fifo_dout;
  fmt_t        w_fmt;
  logic [31:0] w_word;
  logic        w_err;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [10:0] op11_of(input logic [5:0] id);
    case (id)
      ID_AND:  return OP11_AND;
      ID_ADD:  return OP11_ADD;
      ID_ORR:  return OP11_ORR;
      ID_ADDS: return OP11_ADDS;
      ID_EOR:  return OP11_EOR;
      ID_SUB:  return OP11_SUB;
      ID_LSR:  return OP11_LSR;
      ID_LSL:  return OP11_LSL;
      ID_BR:   return OP11_BR;
      ID_ANDS: return OP11_ANDS;
      ID_SUBS: return OP11_SUBS;
      default: return '0;
    endcase
  endfunction

  function automatic logic [9:0] op10_of(input logic [5:0] id);
    case (id)
      ID_ORRI:  return OP10_ORRI;
      ID_EORI:  return OP10_EORI;
      ID_ADDI:  return OP10_ADDI;
      ID_ANDI:  return OP10_ANDI;
      ID_ADDIS: return OP10_ADDIS;
      ID_SUBI:  return OP10_SUBI;
      ID_SUBIS: return OP10_SUBIS;
      ID_ANDIS: return OP10_ANDIS;
      default:  return '0;
    endcase
  endfunction

  // S1 drains into the FIFO when there is room, counting a same-cycle pop as room.
  assign w_pop        = w_fifo_valid && bus.out_ready;
  assign w_s1_adv     = r_vld_p1 && (!w_fifo_full || w_pop);
  assign bus.in_ready = rst_n && (!r_vld_p1 || w_s1_adv);
  assign w_accept     = bus.in_valid && bus.in_ready;

  // ---- stage p1: request register ----
  always_ff @(posedge clk) begin
    if (!rst_n)        r_vld_p1 <= 1'b0;
    else if (w_accept) r_vld_p1 <= 1'b1;
    else if (w_s1_adv) r_vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_id_p1    <= bus.in_id;
      r_rd_p1    <= bus.in_rd;
      r_rn_p1    <= bus.in_rn;
      r_rm_p1    <= bus.in_rm;
      r_shamt_p1 <= bus.in_shamt;
      r_imm_p1   <= bus.in_imm;
    end
  end

  // ---- encode: combinational from p1 into the FIFO push data ----
  always_comb begin
    w_fmt  = id2fmt(r_id_p1);
    w_word = '0;
    w_err  = 1'b0;
    case (w_fmt)
      FMT_R: begin
        if (r_id_p1 == ID_LSL || r_id_p1 == ID_LSR)
          w_word = {op11_of(r_id_p1), 5'd0, r_shamt_p1, r_rn_p1, r_rd_p1};
        else if (r_id_p1 == ID_BR)
          w_word = {op11_of(r_id_p1), 11'd0, r_rn_p1, 5'd0};
        else
          w_word = {op11_of(r_id_p1), r_rm_p1, 6'd0, r_rn_p1, r_rd_p1};
      end
      FMT_I: begin
        if (|r_imm_p1[25:12]) w_err  = 1'b1;
        else                  w_word = {op10_of(r_id_p1), r_imm_p1[11:0], r_rn_p1, r_rd_p1};
      end
      FMT_B:   w_word = {(r_id_p1 == ID_BL) ? OP6_BL : OP6_B, r_imm_p1};
      default: w_err  = 1'b1;
    endcase
  end

  // ---- stage p2: output FIFO ----
  legv8_enc_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_s1_adv),
    .i_data  ({w_err, w_word}),
    .o_full  (w_fifo_full),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_pop) begin
      if (w_fifo_dout[32]) r_err_count <= sat_inc(r_err_count);
      else                 r_enc_count <= sat_inc(r_enc_count);
    end
  end

  assign bus.out_valid = w_fifo_valid;
  assign bus.out_word  = w_fifo_dout[31:0];
  assign bus.out_err   = w_fifo_dout[32];
  assign bus.enc_count = r_enc_count;
  assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_legv8_encoder.sv
// Bench for legv8_encoder: directed encoding/backpressure/reset scenarios plus
// random traffic, checked against an arithmetic encoder and an in-order queue.
module tb_legv8_encoder;
  localparam int CW = 16;

  typedef struct {
    int unsigned id, rd, rn, rm, shamt, imm;
  } req_t;

  typedef struct {
    logic [32:0] v;
    int          stamp;
  } item_t;

  // Opcode per instruction ID (index 0 unused), straight from the ISA tables.
  localparam int unsigned OPC [22] = '{
    0, 'b000101, 'b100101,
    'b1011001000, 'b1101001000, 'b1001000100, 'b1001001000,
    'b1011000100, 'b1101000100, 'b1111000100, 'b1111001000,
    'b10001010000, 'b10001011000, 'b10101010000, 'b10101011000,
    'b11001010000, 'b11001011000, 'b11010011010, 'b11010011011,
    'b11010110000, 'b11101010000, 'b11101011000
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  legv8_encoder_if #(.COUNT_W(CW)) bus_if ();

  legv8_encoder #(.FIFO_DEPTH(4), .COUNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  item_t       exp_q[$];
  logic [32:0] got_q[$];
  int          got_cyc[$];
  logic [CW-1:0] m_enc = '0;
  logic [CW-1:0] m_err = '0;
  bit          dut_acc;
  bit          dut_ir;
  req_t        idle;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic req_t mk(int unsigned id, int unsigned rd, int unsigned rn,
                              int unsigned rm, int unsigned sh, int unsigned imm);
    req_t r;
    r.id = id; r.rd = rd; r.rn = rn; r.rm = rm; r.shamt = sh; r.imm = imm;
    return r;
  endfunction

  function automatic logic [32:0] ref_enc(req_t r);
    int unsigned op, rm, sh, rd;
    if (r.id == 0 || r.id > 21) return {1'b1, 32'h0};
    op = OPC[r.id];
    if (r.id <= 2) return {1'b0, 32'((op << 26) + r.imm)};
    if (r.id <= 10) begin
      if (r.imm >= 4096) return {1'b1, 32'h0};
      return {1'b0, 32'((op << 22) + (r.imm << 10) + (r.rn << 5) + r.rd)};
    end
    rm = r.rm; sh = 0; rd = r.rd;
    if (r.id == 17 || r.id == 18) begin rm = 0; sh = r.shamt; end
    if (r.id == 19) begin rm = 0; sh = 0; rd = 0; end
    return {1'b0, 32'((op << 21) + (rm << 16) + (sh << 10) + (r.rn << 5) + rd)};
  endfunction

  function automatic logic [CW-1:0] sat(logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // One clock: drive at negedge, check settled outputs, then update the model at posedge.
  task automatic tick(input bit rst_b, input bit v, input req_t r, input bit ordy);
    int    n;
    bit    exp_ov, exp_ir, pop, acc;
    item_t it;
    @(negedge clk);
    rst_n           = rst_b;
    bus_if.in_valid = v;
    bus_if.in_id    = 6'(r.id);
    bus_if.in_rd    = 5'(r.rd);
    bus_if.in_rn    = 5'(r.rn);
    bus_if.in_rm    = 5'(r.rm);
    bus_if.in_shamt = 6'(r.shamt);
    bus_if.in_imm   = 26'(r.imm);
    bus_if.out_ready = ordy;
    #1;
    n      = exp_q.size();
    exp_ov = rst_b && n > 0 && (exp_q[0].stamp < cyc);
    pop    = exp_ov && ordy;
    exp_ir = rst_b && (n < 5 || pop);
    check_eq("out_valid", bus_if.out_valid, exp_ov);
    check_eq("in_ready", bus_if.in_ready, exp_ir);
    check_eq("enc_count", bus_if.enc_count, m_enc);
    check_eq("err_count", bus_if.err_count, m_err);
    if (!rst_b) begin
      check_eq("rst_word", bus_if.out_word, 0);
      check_eq("rst_err", bus_if.out_err, 0);
    end
    if (pop) begin
      check_eq("out_data", {bus_if.out_err, bus_if.out_word}, exp_q[0].v);
      got_q.push_back({bus_if.out_err, bus_if.out_word});
      got_cyc.push_back(cyc);
    end
    dut_ir  = bus_if.in_ready;
    dut_acc = v && bus_if.in_ready;
    acc     = v && exp_ir;
    @(posedge clk);
    cyc++;
    if (!rst_b) begin
      exp_q.delete();
      m_enc = '0;
      m_err = '0;
    end else begin
      if (pop) begin
        if (exp_q[0].v[32]) m_err = sat(m_err);
        else                m_enc = sat(m_enc);
        void'(exp_q.pop_front());
      end
      if (acc) begin
        it.v = ref_enc(r);
        it.stamp = cyc;
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic do_reset(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b0, idle, 1'b0);
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) tick(1'b1, 1'b0, idle, 1'b1);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    req_t rq[6];
    req_t r;
    int   idx, nacc, acc_edge;
    idle = mk(0, 0, 0, 0, 0, 0);

    do_reset(3);
    check_eq("reset_valid", bus_if.out_valid, 0);
    check_eq("reset_enc", bus_if.enc_count, 0);
    check_eq("reset_err", bus_if.err_count, 0);

    // ADD X3,X1,X2 and its two-edge latency
    tick(1'b1, 1'b1, mk(12, 3, 1, 2, 0, 0), 1'b1);
    acc_edge = cyc;
    drain(4);
    check_eq("t1_n", got_q.size(), 1);
    check_eq("t1_word", got_q[0], {1'b0, 32'h8B020023});
    check_eq("t1_lat", got_cyc[0] - acc_edge, 1);
    check_eq("t1_enc", bus_if.enc_count, 1);

    got_q.delete(); got_cyc.delete();
    tick(1'b1, 1'b1, mk(5, 5, 6, 0, 0, 100), 1'b1);
    tick(1'b1, 1'b1, mk(18, 1, 2, 0, 4, 0), 1'b1);
    tick(1'b1, 1'b1, mk(19, 0, 30, 0, 0, 0), 1'b1);
    drain(4);
    check_eq("t2_n", got_q.size(), 3);
    check_eq("t2_addi", got_q[0], {1'b0, 32'h910190C5});
    check_eq("t2_lsl", got_q[1], {1'b0, 32'hD3601041});
    check_eq("t2_br", got_q[2], {1'b0, 32'hD60003C0});

    got_q.delete(); got_cyc.delete();
    tick(1'b1, 1'b1, mk(1, 0, 0, 0, 0, 26'h3FFFFFF), 1'b1);
    tick(1'b1, 1'b1, mk(2, 0, 0, 0, 0, 1), 1'b1);
    drain(4);
    check_eq("t3_n", got_q.size(), 2);
    check_eq("t3_b", got_q[0], {1'b0, 32'h17FFFFFF});
    check_eq("t3_bl", got_q[1], {1'b0, 32'h94000001});
    check_eq("t3_gap", got_cyc[1] - got_cyc[0], 1);

    // EOR and ANDS share everything but one opcode bit
    got_q.delete(); got_cyc.delete();
    tick(1'b1, 1'b1, mk(15, 1, 2, 3, 0, 0), 1'b1);
    tick(1'b1, 1'b1, mk(20, 1, 2, 3, 0, 0), 1'b1);
    drain(4);
    check_eq("eor", got_q[0], {1'b0, 32'hCA030041});
    check_eq("ands", got_q[1], {1'b0, 32'hEA030041});

    do_reset(1);
    tick(1'b1, 1'b1, mk(0, 1, 1, 1, 0, 0), 1'b1);
    tick(1'b1, 1'b1, mk(5, 1, 1, 0, 0, 4096), 1'b1);
    drain(4);
    check_eq("t4_w0", got_q[0], {1'b1, 32'h0});
    check_eq("t4_w1", got_q[1], {1'b1, 32'h0});
    check_eq("t4_err", bus_if.err_count, 2);
    check_eq("t4_enc", bus_if.enc_count, 0);

    // Backpressure: S1 plus four FIFO entries hold exactly five requests
    do_reset(1);
    for (int i = 0; i < 6; i++) rq[i] = mk(11 + i, i, i + 1, i + 2, i, 0);
    idx = 0; nacc = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, idx < 6, (idx < 6) ? rq[idx] : idle, 1'b0);
      if (dut_acc) begin idx++; nacc++; end
    end
    check_eq("t5_acc", nacc, 5);
    check_eq("t5_ir", dut_ir, 0);
    for (int i = 0; i < 12 && idx < 6; i++) begin
      tick(1'b1, 1'b1, rq[idx], 1'b1);
      if (dut_acc) idx++;
    end
    check_eq("t5_sixth", idx, 6);
    drain(8);
    check_eq("t5_n", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) check_eq("t5_order", got_q[i], ref_enc(rq[i]));

    // Reset while the FIFO holds three words
    do_reset(1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, mk(12, i, i, i, 0, 0), 1'b0);
    tick(1'b1, 1'b0, idle, 1'b0);
    tick(1'b1, 1'b0, idle, 1'b0);
    check_eq("t6_full", bus_if.out_valid, 1);
    tick(1'b0, 1'b0, idle, 1'b1);
    got_q.delete();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, idle, 1'b1);
    check_eq("t6_stale", got_q.size(), 0);
    check_eq("t6_enc", bus_if.enc_count, 0);
    check_eq("t6_valid", bus_if.out_valid, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      r.id    = $urandom_range(0, 23);
      r.rd    = $urandom_range(0, 31);
      r.rn    = $urandom_range(0, 31);
      r.rm    = $urandom_range(0, 31);
      r.shamt = $urandom_range(0, 63);
      r.imm   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4095) : ($urandom & 32'h03FF_FFFF);
      tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), r, ($urandom_range(0, 2) != 0));
    end
    drain(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
